// File: rtl/m_rf_nwnr_pkg.sv
// Shared helpers for the generic multi-port register file.
package m_rf_nwnr_pkg;

  // Number of storage entries for a given address width.
  function automatic int rf_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/m_rf_nwnr_dff_lr.sv
// Load-enabled data register with synchronous active-high clear; one per read port.
module m_dff_lr #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LOAD,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= '0;
    end else if (LOAD) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/m_rf_nwnr.sv
// Generic register file: 2**AW x DW storage, NUM_WRITE write ports, NUM_READ registered read ports.
module m_rf_nwnr
  import m_rf_nwnr_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int NUM_READ  = 1,
  parameter int NUM_WRITE = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_READ-1:0]    RE,
  input  logic [NUM_READ*AW-1:0] RADDR,
  output logic [NUM_READ*DW-1:0] RDATA,
  input  logic [NUM_WRITE-1:0]   WE,
  input  logic [NUM_WRITE*AW-1:0] WADDR,
  input  logic [NUM_WRITE*DW-1:0] WDATA
);

  localparam int DEPTH = rf_depth(AW);

  logic [DW-1:0] mem [DEPTH];

  // Ports are visited in ascending order, so the last nonblocking update (highest index) wins.
  always_ff @(posedge CLK) begin
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (WE[j]) begin
        mem[WADDR[j*AW +: AW]] <= WDATA[j*DW +: DW];
      end
    end
  end

  // Reads sample the pre-write array contents, giving read-before-write with no bypass.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    m_dff_lr #(
      .DW(DW)
    ) u_rd_reg (
      .CLK (CLK),
      .RST (RST),
      .LOAD(RE[i]),
      .D   (mem[RADDR[i*AW +: AW]]),
      .Q   (RDATA[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_m_rf_nwnr.sv
// Directed self-checking bench for m_rf_nwnr: a 2R2W DW=32/AW=3 instance and a 1R1W AW=4 instance.
module tb_m_rf_nwnr;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  re;
  logic [5:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  we;
  logic [5:0]  waddr;
  logic [63:0] wdata;

  logic        rst_t;
  logic [0:0]  re_t;
  logic [3:0]  raddr_t;
  logic [31:0] rdata_t;
  logic [0:0]  we_t;
  logic [3:0]  waddr_t;
  logic [31:0] wdata_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  m_rf_nwnr #(
    .DW(32), .AW(3), .NUM_READ(2), .NUM_WRITE(2)
  ) dut (
    .CLK(clk), .RST(rst), .RE(re), .RADDR(raddr), .RDATA(rdata),
    .WE(we), .WADDR(waddr), .WDATA(wdata)
  );

  m_rf_nwnr #(
    .DW(32), .AW(4), .NUM_READ(1), .NUM_WRITE(1)
  ) dut_tlb (
    .CLK(clk), .RST(rst_t), .RE(re_t), .RADDR(raddr_t), .RDATA(rdata_t),
    .WE(we_t), .WADDR(waddr_t), .WDATA(wdata_t)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; re = 2'b11; raddr = {3'd1, 3'd0};
    @(negedge clk);
    n_checks++;
    if (rdata[31:0] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_rd0: got %h, expected %h", rdata[31:0], 32'h0);
    end
    n_checks++;
    if (rdata[63:32] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_rd1: got %h, expected %h", rdata[63:32], 32'h0);
    end
    rst = 1'b0; re = 2'b00;
    @(negedge clk);
    n_checks++;
    if (rdata[31:0] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_hold_rd0: got %h, expected %h", rdata[31:0], 32'h0);
    end
    n_checks++;
    if (rdata[63:32] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_hold_rd1: got %h, expected %h", rdata[63:32], 32'h0);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we = 2'b01; waddr[2:0] = 3'd3; wdata[31:0] = 32'hDEADBEEF;
    @(negedge clk);
    we = 2'b00; re = 2'b10; raddr[5:3] = 3'd3;
    @(negedge clk);
    re = 2'b00;
    n_checks++;
    if (rdata[63:32] !== 32'hDEADBEEF) begin
      n_fail++; $display("[TB] FAIL wr_rd1: got %h, expected %h", rdata[63:32], 32'hDEADBEEF);
    end
    n_checks++;
    if (rdata[31:0] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL wr_rd0_untouched: got %h, expected %h", rdata[31:0], 32'h0);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    we = 2'b01; waddr[2:0] = 3'd3; wdata[31:0] = 32'h1234;
    @(negedge clk);
    we = 2'b00;
    n_checks++;
    if (rdata[63:32] !== 32'hDEADBEEF) begin
      n_fail++; $display("[TB] FAIL hold_a: got %h, expected %h", rdata[63:32], 32'hDEADBEEF);
    end
    @(negedge clk);
    n_checks++;
    if (rdata[63:32] !== 32'hDEADBEEF) begin
      n_fail++; $display("[TB] FAIL hold_b: got %h, expected %h", rdata[63:32], 32'hDEADBEEF);
    end
    re = 2'b10; raddr[5:3] = 3'd3;
    @(negedge clk);
    re = 2'b00;
    n_checks++;
    if (rdata[63:32] !== 32'h1234) begin
      n_fail++; $display("[TB] FAIL hold_reload: got %h, expected %h", rdata[63:32], 32'h1234);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    we = 2'b01; waddr[2:0] = 3'd5; wdata[31:0] = 32'hA;
    @(negedge clk);
    we = 2'b01; waddr[2:0] = 3'd5; wdata[31:0] = 32'hB;
    re = 2'b01; raddr[2:0] = 3'd5;
    @(negedge clk);
    we = 2'b00;
    n_checks++;
    if (rdata[31:0] !== 32'hA) begin
      n_fail++; $display("[TB] FAIL rbw_old: got %h, expected %h", rdata[31:0], 32'hA);
    end
    @(negedge clk);
    re = 2'b00;
    n_checks++;
    if (rdata[31:0] !== 32'hB) begin
      n_fail++; $display("[TB] FAIL rbw_new: got %h, expected %h", rdata[31:0], 32'hB);
    end
  endtask

  task automatic test_write_conflict();
    @(negedge clk);
    we = 2'b11; waddr = {3'd7, 3'd7}; wdata = {32'h22, 32'h11};
    @(negedge clk);
    we = 2'b00; re = 2'b01; raddr[2:0] = 3'd7;
    @(negedge clk);
    re = 2'b00;
    n_checks++;
    if (rdata[31:0] !== 32'h22) begin
      n_fail++; $display("[TB] FAIL wr_conflict: got %h, expected %h", rdata[31:0], 32'h22);
    end
  endtask

  task automatic test_reset_cycle_ops();
    @(negedge clk);
    rst = 1'b1; we = 2'b01; waddr[2:0] = 3'd2; wdata[31:0] = 32'h77;
    re = 2'b01; raddr[2:0] = 3'd7;
    @(negedge clk);
    rst = 1'b0; we = 2'b00; re = 2'b00;
    n_checks++;
    if (rdata[31:0] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL rst_read_dropped: got %h, expected %h", rdata[31:0], 32'h0);
    end
    re = 2'b11; raddr = {3'd2, 3'd2};
    @(negedge clk);
    re = 2'b00;
    n_checks++;
    if (rdata[31:0] !== 32'h77) begin
      n_fail++; $display("[TB] FAIL rst_write_kept_rd0: got %h, expected %h", rdata[31:0], 32'h77);
    end
    n_checks++;
    if (rdata[63:32] !== 32'h77) begin
      n_fail++; $display("[TB] FAIL rst_write_kept_rd1: got %h, expected %h", rdata[63:32], 32'h77);
    end
  endtask

  task automatic test_tlb_fill();
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we_t = 1'b1; waddr_t = 4'(i); wdata_t = 32'(i) * 32'h01010101;
    end
    @(negedge clk);
    we_t = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        rst_t = 1'b1;
        @(negedge clk);
        rst_t = 1'b0;
        n_checks++;
        if (rdata_t !== 32'h0) begin
          n_fail++; $display("[TB] FAIL tlb_mid_reset: got %h, expected %h", rdata_t, 32'h0);
        end
      end
      re_t = 1'b1; raddr_t = 4'(i);
      @(negedge clk);
      re_t = 1'b0;
      exp = 32'(i) * 32'h01010101;
      n_checks++;
      if (rdata_t !== exp) begin
        n_fail++; $display("[TB] FAIL tlb_read[%0d]: got %h, expected %h", i, rdata_t, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b0; re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
    rst_t = 1'b0; re_t = '0; raddr_t = '0; we_t = '0; waddr_t = '0; wdata_t = '0;
    test_reset();
    test_write_read();
    test_hold();
    test_same_cycle();
    test_write_conflict();
    test_reset_cycle_ops();
    test_tlb_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
